// File: rtl/cache_arb_pkg.sv
// Shared constants and types for the icache/dcache bus arbiter.
// Tag layout: [12] READ/WRITE, [11:8] transaction type, [0] DATA/INSTR source.
package cache_arb_pkg;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [3:0] MEMORY = 4'b0001;
  localparam logic [3:0] MMIO   = 4'b0010;
  localparam logic [3:0] PORT   = 4'b0011;
  localparam logic [3:0] IRQ    = 4'b0100;

  localparam logic DATA  = 1'b1;
  localparam logic INSTR = 1'b0;

  localparam int TAG_RW_BIT  = 12;
  localparam int TAG_SRC_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } client_t;

  function automatic logic tag_is_write(input logic rw_bit);
    return rw_bit == WRITE;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational grant choice between icache and dcache requests.
// Build macro CACHE_ARB_FIXED_PRIO_EN: dcache always wins ties; otherwise round-robin on last_grant.
module arb_rr_picker
  import cache_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  client_t last_grant,
  output client_t grant
);

`ifdef CACHE_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    if (i_req && !d_req) grant = ICACHE;
    else                 grant = DCACHE;
  end
`else
  // On a tie the client that was not served last time goes next.
  always_comb begin
    if (i_req && d_req) begin
      if (last_grant == DCACHE) grant = ICACHE;
      else                      grant = DCACHE;
    end else if (i_req) begin
      grant = ICACHE;
    end else begin
      grant = DCACHE;
    end
  end
`endif

endmodule

// File: rtl/cache_bus_arbiter.sv
// Two-client arbiter: one of icache/dcache owns the system bus for one transaction at a time.
// Build macro CACHE_ARB_FIXED_PRIO_EN selects fixed dcache priority (see arb_rr_picker).
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] i_req,
  input  logic [TAG_WIDTH-1:0]  i_reqtag,
  input  logic                  i_reqcyc,
  output logic                  i_reqack,
  output logic [DATA_WIDTH-1:0] i_resp,
  output logic [TAG_WIDTH-1:0]  i_resptag,
  output logic                  i_respcyc,
  input  logic                  i_respack,

  input  logic [DATA_WIDTH-1:0] d_req,
  input  logic [TAG_WIDTH-1:0]  d_reqtag,
  input  logic                  d_reqcyc,
  output logic                  d_reqack,
  output logic [DATA_WIDTH-1:0] d_resp,
  output logic [TAG_WIDTH-1:0]  d_resptag,
  output logic                  d_respcyc,
  input  logic                  d_respack,

  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqcyc,
  input  logic                  bus_reqack,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respcyc,
  output logic                  bus_respack
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t       state;
  client_t          grant;
  client_t          last_grant;
  client_t          pick;
  logic [CNT_W-1:0] beat_cnt;

  arb_rr_picker u_picker (
    .i_req      (i_reqcyc),
    .d_req      (d_reqcyc),
    .last_grant (last_grant),
    .grant      (pick)
  );

  logic [DATA_WIDTH-1:0] g_req;
  logic [TAG_WIDTH-1:0]  g_reqtag;
  logic                  g_reqcyc;
  logic                  req_phase;
  logic                  rsp_phase;
  client_t               rsp_dst;
  logic                  rsp_route;
  logic                  dst_respack;
  logic                  req_beat;
  logic                  rsp_beat;

  assign g_req     = (grant == DCACHE) ? d_req    : i_req;
  assign g_reqtag  = (grant == DCACHE) ? d_reqtag : i_reqtag;
  assign g_reqcyc  = (grant == DCACHE) ? d_reqcyc : i_reqcyc;

  assign req_phase = (state == ADDR) || (state == WDATA);
  assign rsp_phase = (state == RDATA);

  // Responses are steered by the source bit of the returning tag; a beat addressed
  // to the client that does not own the bus is never presented to it.
  assign rsp_dst     = client_t'(bus_resptag[TAG_SRC_BIT]);
  assign rsp_route   = rsp_phase && (rsp_dst == grant);
  assign dst_respack = (rsp_dst == DCACHE) ? d_respack : i_respack;

  assign req_beat = req_phase && g_reqcyc && bus_reqack;
  assign rsp_beat = rsp_route && bus_respcyc && dst_respack;

  always_comb begin
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    i_reqack    = 1'b0;
    d_reqack    = 1'b0;
    i_resp      = '0;
    i_resptag   = '0;
    i_respcyc   = 1'b0;
    d_resp      = '0;
    d_resptag   = '0;
    d_respcyc   = 1'b0;
    if (req_phase) begin
      bus_req    = g_req;
      bus_reqtag = g_reqtag;
      bus_reqcyc = g_reqcyc;
      i_reqack   = (grant == ICACHE) && bus_reqack;
      d_reqack   = (grant == DCACHE) && bus_reqack;
    end
    if (rsp_phase) begin
      i_resp    = bus_resp;
      i_resptag = bus_resptag;
      d_resp    = bus_resp;
      d_resptag = bus_resptag;
      if (rsp_route) begin
        i_respcyc   = bus_respcyc && (rsp_dst == ICACHE);
        d_respcyc   = bus_respcyc && (rsp_dst == DCACHE);
        bus_respack = dst_respack;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= DCACHE;
      last_grant <= DCACHE;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_reqcyc || d_reqcyc) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (req_beat) begin
            beat_cnt <= '0;
            state    <= tag_is_write(g_reqtag[TAG_RW_BIT]) ? WDATA : RDATA;
          end
        end
        WDATA: begin
          if (req_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RDATA: begin
          if (rsp_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed scoreboard bench for cache_bus_arbiter (default and CACHE_ARB_FIXED_PRIO_EN builds).
module tb_cache_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int BEATS = 8;
  localparam logic [TW-1:0] I_RD = 13'h1100;
  localparam logic [TW-1:0] D_RD = 13'h1101;
  localparam logic [TW-1:0] D_WR = 13'h0101;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [DW-1:0] c_req     [2];
  logic [TW-1:0] c_reqtag  [2];
  logic          c_reqcyc  [2];
  logic          c_reqack  [2];
  logic [DW-1:0] c_resp    [2];
  logic [TW-1:0] c_resptag [2];
  logic          c_respcyc [2];
  logic          c_respack [2];

  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqcyc;
  logic          bus_reqack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respcyc;
  logic          bus_respack;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  cache_bus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .i_req(c_req[0]), .i_reqtag(c_reqtag[0]), .i_reqcyc(c_reqcyc[0]), .i_reqack(c_reqack[0]),
    .i_resp(c_resp[0]), .i_resptag(c_resptag[0]), .i_respcyc(c_respcyc[0]), .i_respack(c_respack[0]),
    .d_req(c_req[1]), .d_reqtag(c_reqtag[1]), .d_reqcyc(c_reqcyc[1]), .d_reqack(c_reqack[1]),
    .d_resp(c_resp[1]), .d_resptag(c_resptag[1]), .d_respcyc(c_respcyc[1]), .d_respack(c_respack[1]),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return bus_reqcyc | bus_respack | (|bus_req) | (|bus_reqtag) |
           c_reqack[0] | c_reqack[1] | c_respcyc[0] | c_respcyc[1] |
           (|c_resp[0]) | (|c_resp[1]) | (|c_resptag[0]) | (|c_resptag[1]);
  endfunction

  // Client c issues an address beat plus (nbeats-1) data beats; the bus withholds ack for ack_hold cycles.
  task automatic send_req(input int c, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                          input int nbeats, input logic [DW-1:0] dbase, input int ack_hold);
    int idx = 0;
    int cyc = 0;
    logic [DW-1:0] e;
    for (int i = 0; i < nbeats; i++) exp_q.push_back((i == 0) ? addr : dbase + DW'(i));
    c_req[c] = addr; c_reqtag[c] = tag; c_reqcyc[c] = 1'b1;
    bus_reqack = (ack_hold == 0);
    while (idx < nbeats && cyc < 64) begin
      @(negedge clk);
      if (bus_reqcyc && bus_reqack) begin
        e = exp_q.pop_front();
        chk("bus_req", bus_req, e);
        chk("bus_reqtag", DW'(bus_reqtag), DW'(tag));
        chk1("own_reqack", c_reqack[c], 1'b1);
        chk1("other_reqack", c_reqack[1-c], 1'b0);
        idx++;
      end else if (bus_reqcyc) begin
        chk("stall_req", bus_req, exp_q[0]);
        chk("stall_reqtag", DW'(bus_reqtag), DW'(tag));
        chk1("stall_reqack", c_reqack[c], 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
      if (idx < nbeats) begin
        c_req[c] = (idx == 0) ? addr : dbase + DW'(idx);
      end else begin
        c_reqcyc[c] = 1'b0; c_req[c] = '0; c_reqtag[c] = '0;
      end
      bus_reqack = (cyc >= ack_hold);
    end
    bus_reqack = 1'b0;
    chk("req_beats", DW'(idx), DW'(nbeats));
  endtask

  // Bus returns BEATS response beats to client c; optional consumer stall and mid-burst reset.
  task automatic recv_resp(input int c, input logic [TW-1:0] tag, input logic [DW-1:0] base,
                           input int stall_beat, input int stall_len, input int abort_at);
    int k = 0;
    int sent = 1;
    int stall = 0;
    int cyc = 0;
    logic [DW-1:0] e;
    bus_resptag = tag; bus_respcyc = 1'b1; bus_resp = base;
    exp_q.push_back(base);
    c_respack[c] = !(k == stall_beat && stall < stall_len);
    while (k < BEATS && cyc < 64) begin
      @(negedge clk);
      chk1("own_respcyc", c_respcyc[c], 1'b1);
      chk1("other_respcyc", c_respcyc[1-c], 1'b0);
      chk1("bus_respack", bus_respack, c_respack[c]);
      chk("resptag", DW'(c_resptag[c]), DW'(tag));
      if (c_respcyc[c] && c_respack[c]) begin
        e = exp_q.pop_front();
        chk("resp", c_resp[c], e);
        k++;
      end else begin
        stall++;
      end
      @(posedge clk); #1;
      cyc++;
      if (k == abort_at) begin
        #1 reset = 1'b0;
        #1;
        chk1("rst_async_zero", any_out(), 1'b0);
        exp_q.delete();
        bus_respcyc = 1'b0; bus_resptag = '0; bus_resp = '0; c_respack[c] = 1'b0;
        return;
      end
      if (k < BEATS && k == sent) begin
        bus_resp = base + DW'(k);
        exp_q.push_back(bus_resp);
        sent++;
      end
      c_respack[c] = !(k == stall_beat && stall < stall_len);
    end
    bus_respcyc = 1'b0; bus_resptag = '0; bus_resp = '0; c_respack[c] = 1'b0;
    chk("resp_beats", DW'(k), DW'(BEATS));
  endtask

  // A stray response in IDLE must not reach any client.
  task automatic post_idle_check(input int c, input logic [TW-1:0] tag);
    bus_respcyc = 1'b1; bus_resptag = tag; bus_resp = 64'hDEAD; c_respack[c] = 1'b1;
    @(negedge clk);
    chk1("idle_respcyc", c_respcyc[c], 1'b0);
    chk1("idle_respack", bus_respack, 1'b0);
    chk1("idle_reqcyc", bus_reqcyc, 1'b0);
    @(posedge clk); #1;
    bus_respcyc = 1'b0; bus_resptag = '0; bus_resp = '0; c_respack[c] = 1'b0;
  endtask

  int first_c;
  logic [DW-1:0] tie_addr [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      c_req[i] = '0; c_reqtag[i] = '0; c_reqcyc[i] = 1'b0; c_respack[i] = 1'b0;
    end
    bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 1'b0;

    repeat (2) @(negedge clk);
    chk1("reset_outputs", any_out(), 1'b0);
    @(posedge clk); #1 reset = 1'b1;

    // dcache line write: address + 8 data beats, no response phase
    send_req(1, 64'h2040, D_WR, 9, 64'hD0D0_0000_0000_0000, 0);
    post_idle_check(1, D_WR);

    // icache line read with one-cycle request latency
    c_req[0] = 64'h1000; c_reqtag[0] = I_RD; c_reqcyc[0] = 1'b1; bus_reqack = 1'b0;
    @(negedge clk); chk1("lat_idle", bus_reqcyc, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk1("lat_one", bus_reqcyc, 1'b1);
    @(posedge clk); #1;
    send_req(0, 64'h1000, I_RD, 1, '0, 0);
    recv_resp(0, I_RD, 64'hA100_0000_0000_0000, -1, 0, -1);
    post_idle_check(0, I_RD);

    // simultaneous requests; icache was served last so dcache wins
    c_req[0] = 64'h3000; c_reqtag[0] = I_RD; c_reqcyc[0] = 1'b1;
    c_req[1] = 64'h4000; c_reqtag[1] = D_RD; c_reqcyc[1] = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); chk("arb_first", bus_req, 64'h4000);
    @(posedge clk); #1;
    send_req(1, 64'h4000, D_RD, 1, '0, 0);
    recv_resp(1, D_RD, 64'hB400_0000_0000_0000, -1, 0, -1);

    // dcache re-requests while icache is still waiting
`ifdef CACHE_ARB_FIXED_PRIO_EN
    first_c = 1;
`else
    first_c = 0;
`endif
    tie_addr[0] = 64'h3000; tie_addr[1] = 64'h5000;
    c_req[1] = 64'h5000; c_reqtag[1] = D_RD; c_reqcyc[1] = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); chk("arb_second", bus_req, tie_addr[first_c]);
    @(posedge clk); #1;
    send_req(first_c, tie_addr[first_c], (first_c == 1) ? D_RD : I_RD, 1, '0, 0);
    recv_resp(first_c, (first_c == 1) ? D_RD : I_RD, 64'hC000_0000_0000_0000, -1, 0, -1);
    send_req(1 - first_c, tie_addr[1-first_c], (first_c == 1) ? I_RD : D_RD, 1, '0, 0);
    recv_resp(1 - first_c, (first_c == 1) ? I_RD : D_RD, 64'hC100_0000_0000_0000, -1, 0, -1);

    // bus withholds the address ack for 5 cycles in ADDR
    send_req(1, 64'h6000, D_RD, 1, '0, 6);
    recv_resp(1, D_RD, 64'hE600_0000_0000_0000, -1, 0, -1);

    // icache stalls its response consumer for 3 cycles at beat 2
    send_req(0, 64'h7000, I_RD, 1, '0, 0);
    recv_resp(0, I_RD, 64'hF700_0000_0000_0000, 2, 3, -1);
    post_idle_check(0, I_RD);

    // reset asserted at read beat 4, then a fresh transaction
    send_req(0, 64'h8000, I_RD, 1, '0, 0);
    recv_resp(0, I_RD, 64'h1800_0000_0000_0000, -1, 0, 4);
    @(negedge clk); chk1("rst_hold_zero", any_out(), 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    send_req(1, 64'h9000, D_RD, 1, '0, 0);
    recv_resp(1, D_RD, 64'h2900_0000_0000_0000, -1, 0, -1);
    post_idle_check(1, D_RD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
